// File: rtl/mux_sched_pkg.sv
// Shared constants and FSM state type for the round-robin mux scheduler.
package mux_sched_pkg;

  localparam int unsigned NUM_CH = 31;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    HOLD
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: lowest requesting index at or above ptr,
// otherwise the lowest requesting index below ptr.
module rr_pick
  import mux_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = mux_sched_pkg::NUM_CH,
  parameter int unsigned SEL_W  = mux_sched_pkg::SEL_W
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              any,
  output logic [SEL_W-1:0]  idx
);

  logic             hi_found;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;

  // Scan downward so the lowest matching index in each half wins.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (SEL_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end else begin
          lo_idx = SEL_W'(i);
        end
      end
    end
  end

  assign any = |req;
  assign idx = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one NUM_CH:1 mux; grants a channel, samples the mux
// output and presents it on a registered valid/ready stage.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = mux_sched_pkg::NUM_CH,
  parameter int unsigned SEL_W  = mux_sched_pkg::SEL_W,
  parameter int unsigned DATA_W = mux_sched_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [DATA_W-1:0] mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] grant,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic [NUM_CH-1:0] pick_oh;

  rr_pick #(
    .NUM_CH(NUM_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req(req),
    .ptr(ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign pick_oh = {{(NUM_CH - 1){1'b0}}, 1'b1} << pick_idx;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    grant_d     = '0;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          grant_d = pick_oh;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        out_data_d  = mux_out;
        out_ch_d    = sel_q;
        out_valid_d = 1'b1;
        ptr_d       = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
        state_d     = HOLD;
      end
      HOLD: begin
        // ptr_q already points past the channel being held, so the next pick is fair.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (pick_any) begin
            sel_d   = pick_idx;
            grant_d = pick_oh;
            state_d = SAMPLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Scoreboard bench for mux_rr_sched: expected grant order and output beats are queued
// by the stimulus and consumed by a negedge monitor.
module tb_mux_rr_sched;

  localparam int unsigned NUM_CH = 31;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 2;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] req;
  logic [DATA_W-1:0] mux_out;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] grant;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;

  logic [DATA_W-1:0] mem [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic              auto_clr;

  int unsigned                exp_ch[$];
  logic [SEL_W+DATA_W-1:0]    exp_out[$];

  int n_checks;
  int n_errors;

  mux_rr_sched dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mux_out  (mux_out),
    .sel      (sel),
    .grant    (grant),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Behavioural model of the shared mux.
  assign mux_out = (sel < SEL_W'(NUM_CH)) ? mem[sel] : 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] onehot(input int unsigned ch);
    logic [NUM_CH-1:0] one;
    one = 1;
    return one << ch;
  endfunction

  task automatic set_req(input logic [NUM_CH-1:0] v);
    pending = v;
    req     = v;
  endtask

  task automatic expect_ch(input int unsigned ch);
    exp_ch.push_back(ch);
    exp_out.push_back({SEL_W'(ch), mem[ch]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_ch.size() != 0 || exp_out.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(exp_ch.size() + exp_out.size()), 64'd0);
  endtask

  task automatic wait_grants(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_ch.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_grant_timeout"}, 64'(exp_ch.size()), 64'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_valid_timeout"}, 64'(out_valid), 64'd1);
  endtask

  // Monitor: grant order, grant shape, output beats; models requesters dropping req.
  always @(negedge clk) begin
    if (!reset) begin
      if (grant != '0) begin
        check("grant_onehot", 64'(grant), 64'(onehot(sel)));
        check("grant_with_valid", 64'(out_valid), 64'd0);
        if (exp_ch.size() > 0) check("grant_order", 64'(sel), 64'(exp_ch.pop_front()));
        else check("unexpected_grant", 64'(grant), 64'd0);
        if (auto_clr) begin
          pending = pending & ~grant;
          req     = pending;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() > 0) check("out_beat", 64'({out_ch, out_data}), 64'(exp_out.pop_front()));
        else check("unexpected_beat", 64'(out_valid), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [NUM_CH-1:0] r;
    n_checks  = 0;
    n_errors  = 0;
    auto_clr  = 1'b1;
    out_ready = 1'b1;
    pending   = '0;
    req       = '0;
    for (int i = 0; i < int'(NUM_CH); i++) mem[i] = 2'(i);
    reset = 1'b1;
    #1;
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Single request with exact latency.
    mem[12] = 2'b10;
    set_req(onehot(12));
    expect_ch(12);
    step();
    check("single_sel", 64'(sel), 64'd12);
    check("single_grant", 64'(grant), 64'(onehot(12)));
    step();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'b10);
    check("single_ch", 64'(out_ch), 64'd12);
    check("single_grant_low", 64'(grant), 64'd0);
    step();
    check("single_idle", 64'(out_valid), 64'd0);
    wait_drain("single", 10);
    mem[12] = 2'(12);

    // Asynchronous reset while holding a stalled beat.
    out_ready = 1'b0;
    set_req(onehot(5));
    exp_ch.push_back(5);
    wait_valid("rsthold", 10);
    step();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_sel", 64'(sel), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_ch", 64'(out_ch), 64'd0);
    set_req('0);
    exp_ch.delete();
    exp_out.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    check("midrst_no_regrant", 64'(grant), 64'd0);

    // All channels requesting: 0..30 then 0, starting from a freshly reset ptr.
    auto_clr = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) expect_ch(i);
    expect_ch(0);
    set_req('1);
    wait_grants("allreq", 100);
    set_req('0);
    wait_drain("allreq", 10);
    auto_clr = 1'b1;

    // Wrap: serve 28 so ptr lands on 29, then {3,29,30} -> 29, 30, 3.
    expect_ch(28);
    set_req(onehot(28));
    wait_drain("pre_wrap", 10);
    expect_ch(29);
    expect_ch(30);
    expect_ch(3);
    set_req(onehot(3) | onehot(29) | onehot(30));
    wait_drain("wrap", 20);

    // Backpressure: stalled beat stays frozen while req moves around.
    out_ready = 1'b0;
    expect_ch(7);
    set_req(onehot(7));
    wait_valid("bp", 10);
    for (int k = 0; k < 5; k++) begin
      r = onehot(2) | onehot(20);
      if (k % 2 == 1) r = r | onehot(25);
      set_req(r);
      step();
      check("bp_ch", 64'(out_ch), 64'd7);
      check("bp_data", 64'(out_data), 64'(mem[7]));
      check("bp_sel", 64'(sel), 64'd7);
      check("bp_grant", 64'(grant), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
    end
    expect_ch(20);
    expect_ch(2);
    out_ready = 1'b1;
    step();
    check("bp_b2b_grant", 64'(grant), 64'(onehot(20)));
    check("bp_b2b_valid", 64'(out_valid), 64'd0);
    wait_drain("bp", 20);

    // Idle: nothing moves, then a lone request on the top channel.
    set_req('0);
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_grant", 64'(grant), 64'd0);
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_sel", 64'(sel), 64'd2);
    end
    expect_ch(30);
    set_req(onehot(30));
    step();
    check("top_sel", 64'(sel), 64'd30);
    wait_drain("top", 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
